// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared port count and arbiter state encoding
package mem_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-way round-robin pick, one-hot grant
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 prio,
    output logic [NUM_PORTS-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port data memory arbiter with bus lock
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [1:0]           lock,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wdata0,
    input  logic [DATA_W-1:0]    wdata1,
    output logic [1:0]           gnt,
    output logic [1:0]           rvalid,
    output logic [DATA_W-1:0]    rdata,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 MemWrite,
    output logic                 MemRead,
    input  logic [DATA_W-1:0]    mem_rd_data
);

    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic       pend_q, pend_d;
    logic       tag_q, tag_d;
    logic [1:0] rr_gnt;
    logic       gnt_any;
    logic       gnt_port;
    logic       sel_we;

    rr_pick2 u_rr_pick2 (
        .req  (req),
        .prio (prio_q),
        .gnt  (rr_gnt)
    );

    // Grant is gated by rst_n so strobes stay quiet while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (state_q == ARB) begin
                gnt = rr_gnt;
            end else if (req[owner_q]) begin
                gnt[owner_q] = 1'b1;
            end
        end
    end

    assign gnt_any  = |gnt;
    assign gnt_port = gnt[1];
    assign sel_we   = gnt_port ? we[1] : we[0];

    always_comb begin
        mem_addr = '0;
        wr_data  = '0;
        if (gnt_any) begin
            mem_addr = gnt_port ? addr1  : addr0;
            wr_data  = gnt_port ? wdata1 : wdata0;
        end
    end

    assign MemWrite = gnt_any & sel_we;
    assign MemRead  = gnt_any & ~sel_we;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        pend_d  = MemRead;
        tag_d   = gnt_port;
        case (state_q)
            ARB: begin
                if (gnt_any) begin
                    prio_d = ~gnt_port;
                    if (lock[gnt_port]) begin
                        state_d = LOCKED;
                        owner_d = gnt_port;
                    end
                end
            end
            LOCKED: begin
                // The unlocking access is still granted; release takes effect next cycle.
                if (!req[owner_q] || !lock[owner_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            pend_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
        end
    end

    assign rvalid = pend_q ? (tag_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = pend_q ? mem_rd_data : '0;

endmodule
